// File: rtl/pc_flow_controller.sv
// pc_flow_controller
//
// Steers the fetch pipeline around SPARC-style delayed control transfers.
// A small four-state FSM (RST, FILL, RUN, DSLOT) decides whether PC/nPC and
// the IF/ID register advance, where the next nPC comes from, when the
// delay-slot instruction is squashed, and when a bubble goes into ID/EX.
//
// Ports
//   clk        rising-edge clock
//   R_n        synchronous active-low reset
//   id_valid   ID stage holds a valid instruction
//   stall      load-use hazard from the hazard unit
//   is_branch  ID instruction is a Bicc
//   BI         branch condition true
//   ba         ID branch is branch-always
//   a_bit      annul bit I[29]
//   CALL       ID instruction is a call
//   J          ID instruction is a jump
//   J_L        ID instruction is a jmpl
//   nPC_sel    00 sequential, 01 TAG target, 10 ALU target
//   PC_LE      PC load enable
//   nPC_LE     nPC load enable
//   IF_ID_LE   IF/ID load enable
//   IF_ID_R    squash IF/ID at the next edge
//   ID_EX_nop  inject a bubble into ID/EX
//   dcti_err   sticky: control transfer found in a delay slot
//   redir_cnt  saturating count of accepted redirects

module pc_flow_controller (
    input  logic       clk,
    input  logic       R_n,
    input  logic       id_valid,
    input  logic       stall,
    input  logic       is_branch,
    input  logic       BI,
    input  logic       ba,
    input  logic       a_bit,
    input  logic       CALL,
    input  logic       J,
    input  logic       J_L,
    output logic [1:0] nPC_sel,
    output logic       PC_LE,
    output logic       nPC_LE,
    output logic       IF_ID_LE,
    output logic       IF_ID_R,
    output logic       ID_EX_nop,
    output logic       dcti_err,
    output logic [7:0] redir_cnt
);

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DSLOT = 2'd3;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_TAG = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    logic [1:0] state_q, state_d;
    logic       dcti_err_q, dcti_err_d;
    logic [7:0] redir_cnt_q, redir_cnt_d;

    logic is_cti;
    logic take;
    logic annul;
    logic accept;

    // Decode of the ID instruction, independent of state.
    always_comb begin
        is_cti = is_branch | CALL | J | J_L;
        take   = (is_branch & BI) | CALL | J | J_L;
        annul  = is_branch & a_bit & (~BI | ba);
        accept = (state_q == ST_RUN) & id_valid & ~stall;
    end

    // Next-state and sticky/counter updates. Any accepted control transfer,
    // taken or not, owns a delay slot, so it always moves to DSLOT.
    always_comb begin
        state_d     = state_q;
        dcti_err_d  = dcti_err_q;
        redir_cnt_d = redir_cnt_q;
        case (state_q)
            ST_RST:   state_d = ST_FILL;
            ST_FILL:  state_d = ST_RUN;
            ST_RUN: begin
                if (accept && is_cti) begin
                    state_d = ST_DSLOT;
                end
                if (accept && take && (redir_cnt_q != 8'hFF)) begin
                    redir_cnt_d = redir_cnt_q + 8'd1;
                end
            end
            ST_DSLOT: begin
                if (!stall) begin
                    state_d = ST_RUN;
                    if (id_valid && is_cti) begin
                        dcti_err_d = 1'b1;
                    end
                end
            end
            default:  state_d = ST_RST;
        endcase
    end

    // Pipeline control outputs. Defaults are the reset values; a low R_n
    // forces them regardless of state so the pipeline is frozen immediately.
    always_comb begin
        nPC_sel   = SEL_SEQ;
        PC_LE     = 1'b0;
        nPC_LE    = 1'b0;
        IF_ID_LE  = 1'b0;
        IF_ID_R   = 1'b1;
        ID_EX_nop = 1'b1;
        if (R_n) begin
            case (state_q)
                ST_FILL: begin
                    PC_LE    = 1'b1;
                    nPC_LE   = 1'b1;
                    IF_ID_LE = 1'b1;
                    IF_ID_R  = 1'b0;
                end
                ST_RUN, ST_DSLOT: begin
                    IF_ID_R = 1'b0;
                    if (!stall) begin
                        PC_LE     = 1'b1;
                        nPC_LE    = 1'b1;
                        IF_ID_LE  = 1'b1;
                        ID_EX_nop = 1'b0;
                        if (accept) begin
                            IF_ID_R = annul;
                            if (is_branch && BI) begin
                                nPC_sel = SEL_TAG;
                            end else if (CALL) begin
                                nPC_sel = SEL_TAG;
                            end else if (J || J_L) begin
                                nPC_sel = SEL_ALU;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!R_n) begin
            state_q     <= ST_RST;
            dcti_err_q  <= 1'b0;
            redir_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            dcti_err_q  <= dcti_err_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign dcti_err  = dcti_err_q;
    assign redir_cnt = redir_cnt_q;

endmodule

// File: tb/tb_pc_flow_controller.sv
// tb_pc_flow_controller
//
// Bench for pc_flow_controller: a directed vector table through reset,
// branches, annulling, stalls, delay-slot errors and mid-slot reset; a
// randomized run against a cycle-level reference model; and a long run of
// taken branches to push the redirect counter into saturation.
//
// Outputs are packed as {nPC_sel, PC_LE, nPC_LE, IF_ID_LE, IF_ID_R,
// ID_EX_nop, dcti_err, redir_cnt} for comparison.

module tb_pc_flow_controller;

    logic       clk;
    logic       R_n;
    logic       id_valid;
    logic       stall;
    logic       is_branch;
    logic       BI;
    logic       ba;
    logic       a_bit;
    logic       CALL;
    logic       J;
    logic       J_L;
    logic [1:0] nPC_sel;
    logic       PC_LE;
    logic       nPC_LE;
    logic       IF_ID_LE;
    logic       IF_ID_R;
    logic       ID_EX_nop;
    logic       dcti_err;
    logic [7:0] redir_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0]  ins;   // {R_n, id_valid, stall, is_branch, BI, ba, a_bit, CALL, J, J_L}
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[31];

    // Reference model: cycles since reset release (saturating at 2), whether
    // the next ID instruction sits in a delay slot, sticky error and count.
    int model_age;
    bit model_slot;
    bit model_err;
    int model_cnt;

    pc_flow_controller dut (
        .clk       (clk),
        .R_n       (R_n),
        .id_valid  (id_valid),
        .stall     (stall),
        .is_branch (is_branch),
        .BI        (BI),
        .ba        (ba),
        .a_bit     (a_bit),
        .CALL      (CALL),
        .J         (J),
        .J_L       (J_L),
        .nPC_sel   (nPC_sel),
        .PC_LE     (PC_LE),
        .nPC_LE    (nPC_LE),
        .IF_ID_LE  (IF_ID_LE),
        .IF_ID_R   (IF_ID_R),
        .ID_EX_nop (ID_EX_nop),
        .dcti_err  (dcti_err),
        .redir_cnt (redir_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [9:0] ins, input logic [7:0] ctl, input logic [7:0] cnt);
        vec_t v;
        v.ins = ins;
        v.exp = {ctl, cnt};
        return v;
    endfunction

    function automatic logic [15:0] packOutputs();
        return {nPC_sel, PC_LE, nPC_LE, IF_ID_LE, IF_ID_R, ID_EX_nop, dcti_err, redir_cnt};
    endfunction

    task automatic applyStimulus(input logic [9:0] ins);
        {R_n, id_valid, stall, is_branch, BI, ba, a_bit, CALL, J, J_L} = ins;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %04h expected %04h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the model state plus current inputs.
    function automatic logic [15:0] modelOutputs();
        logic [1:0] sel;
        logic [2:0] le;
        logic       sq;
        logic       nop;
        sel = 2'b00;
        le  = 3'b000;
        sq  = 1'b1;
        nop = 1'b1;
        if (R_n && model_age == 1) begin
            le = 3'b111;
            sq = 1'b0;
        end else if (R_n && model_age >= 2) begin
            sq = 1'b0;
            if (!stall) begin
                le  = 3'b111;
                nop = 1'b0;
                if (!model_slot && id_valid) begin
                    sq = is_branch & a_bit & (~BI | ba);
                    if (is_branch && BI) sel = 2'b01;
                    else if (CALL)       sel = 2'b01;
                    else if (J || J_L)   sel = 2'b10;
                end
            end
        end
        return {sel, le, sq, nop, model_err, 8'(model_cnt)};
    endfunction

    task automatic modelAdvance();
        bit any_cti;
        bit taken;
        any_cti = is_branch | CALL | J | J_L;
        taken   = (is_branch & BI) | CALL | J | J_L;
        if (!R_n) begin
            model_age  = 0;
            model_slot = 0;
            model_err  = 0;
            model_cnt  = 0;
        end else if (model_age < 2) begin
            model_age++;
        end else if (!stall) begin
            if (model_slot) begin
                if (id_valid && any_cti) model_err = 1;
                model_slot = 0;
            end else if (id_valid) begin
                if (any_cti) model_slot = 1;
                if (taken && model_cnt < 255) model_cnt++;
            end
        end
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Directed vectors, applied in order from a reset state.
        vecs[0]  = mk(10'b0_1_1_1_1_0_0_0_0_0, 8'b00_000_1_1_0, 8'd0);
        vecs[1]  = mk(10'b1_0_0_0_0_0_0_0_0_0, 8'b00_000_1_1_0, 8'd0);
        vecs[2]  = mk(10'b1_1_0_1_1_0_0_0_0_0, 8'b00_111_0_1_0, 8'd0);
        vecs[3]  = mk(10'b1_1_0_1_1_0_0_0_0_0, 8'b01_111_0_0_0, 8'd0);
        vecs[4]  = mk(10'b1_1_0_0_0_0_0_0_0_0, 8'b00_111_0_0_0, 8'd1);
        vecs[5]  = mk(10'b1_1_0_1_0_0_1_0_0_0, 8'b00_111_1_0_0, 8'd1);
        vecs[6]  = mk(10'b1_0_0_0_0_0_0_0_0_0, 8'b00_111_0_0_0, 8'd1);
        vecs[7]  = mk(10'b1_1_0_1_1_1_1_0_0_0, 8'b01_111_1_0_0, 8'd1);
        vecs[8]  = mk(10'b1_0_1_0_0_0_0_0_0_0, 8'b00_000_0_1_0, 8'd2);
        vecs[9]  = mk(10'b1_0_0_0_0_0_0_0_0_0, 8'b00_111_0_0_0, 8'd2);
        vecs[10] = mk(10'b1_1_1_0_0_0_0_0_0_1, 8'b00_000_0_1_0, 8'd2);
        vecs[11] = mk(10'b1_1_1_0_0_0_0_0_0_1, 8'b00_000_0_1_0, 8'd2);
        vecs[12] = mk(10'b1_1_1_0_0_0_0_0_0_1, 8'b00_000_0_1_0, 8'd2);
        vecs[13] = mk(10'b1_1_0_0_0_0_0_0_0_1, 8'b10_111_0_0_0, 8'd2);
        vecs[14] = mk(10'b1_0_0_0_0_0_0_0_0_0, 8'b00_111_0_0_0, 8'd3);
        vecs[15] = mk(10'b1_0_0_1_1_0_0_0_0_0, 8'b00_111_0_0_0, 8'd3);
        vecs[16] = mk(10'b1_1_0_0_0_0_0_1_0_0, 8'b01_111_0_0_0, 8'd3);
        vecs[17] = mk(10'b1_1_0_0_0_0_0_1_0_0, 8'b00_111_0_0_0, 8'd4);
        vecs[18] = mk(10'b1_1_0_0_0_0_0_0_1_0, 8'b10_111_0_0_1, 8'd4);
        vecs[19] = mk(10'b1_0_0_0_0_0_0_0_0_0, 8'b00_111_0_0_1, 8'd5);
        vecs[20] = mk(10'b1_1_0_0_0_0_0_1_0_0, 8'b01_111_0_0_1, 8'd5);
        vecs[21] = mk(10'b0_1_0_0_0_0_0_1_0_0, 8'b00_000_1_1_1, 8'd6);
        vecs[22] = mk(10'b1_0_0_0_0_0_0_0_0_0, 8'b00_000_1_1_0, 8'd0);
        vecs[23] = mk(10'b1_0_0_0_0_0_0_0_0_0, 8'b00_111_0_1_0, 8'd0);
        vecs[24] = mk(10'b1_1_0_1_0_0_0_0_0_0, 8'b00_111_0_0_0, 8'd0);
        vecs[25] = mk(10'b1_1_0_1_1_0_0_0_0_0, 8'b00_111_0_0_0, 8'd0);
        vecs[26] = mk(10'b1_1_0_1_1_0_0_1_1_0, 8'b01_111_0_0_1, 8'd0);
        vecs[27] = mk(10'b1_1_1_0_0_0_0_0_1_0, 8'b00_000_0_1_1, 8'd1);
        vecs[28] = mk(10'b1_0_0_0_0_0_0_0_0_0, 8'b00_111_0_0_1, 8'd1);
        vecs[29] = mk(10'b1_1_0_0_0_0_0_1_1_0, 8'b01_111_0_0_1, 8'd1);
        vecs[30] = mk(10'b1_0_0_0_0_0_0_0_0_0, 8'b00_111_0_0_1, 8'd2);

        applyStimulus(10'b0_0_0_0_0_0_0_0_0_0);
        repeat (2) nextEdge();

        for (int i = 0; i < 31; i++) begin
            applyStimulus(vecs[i].ins);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), packOutputs(), vecs[i].exp);
            nextEdge();
        end

        // Randomized run against the model, starting from a reset cycle.
        applyStimulus(10'b0_0_0_0_0_0_0_0_0_0);
        nextEdge();
        model_age  = 0;
        model_slot = 0;
        model_err  = 0;
        model_cnt  = 0;
        for (int i = 0; i < 3000; i++) begin
            R_n       = ($urandom_range(0, 99) != 0);
            id_valid  = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            is_branch = ($urandom_range(0, 2) == 0);
            BI        = $urandom_range(0, 1) == 1;
            ba        = ($urandom_range(0, 3) == 0);
            a_bit     = $urandom_range(0, 1) == 1;
            CALL      = ($urandom_range(0, 5) == 0);
            J         = ($urandom_range(0, 7) == 0);
            J_L       = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            checkOutput($sformatf("rand%0d", i), packOutputs(), modelOutputs());
            nextEdge();
            modelAdvance();
        end

        // Counter saturation: a long run of taken branches, each followed by
        // a quiet delay slot.
        applyStimulus(10'b0_0_0_0_0_0_0_0_0_0);
        nextEdge();
        applyStimulus(10'b1_0_0_0_0_0_0_0_0_0);
        repeat (2) nextEdge();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(10'b1_1_0_1_1_0_0_0_0_0);
            @(negedge clk);
            checkOutput($sformatf("sat%0d", i), {nPC_sel, redir_cnt},
                        {2'b01, (i > 255) ? 8'd255 : 8'(i)});
            nextEdge();
            applyStimulus(10'b1_0_0_0_0_0_0_0_0_0);
            nextEdge();
        end
        @(negedge clk);
        checkOutput("sat_final", {8'd0, redir_cnt}, 16'h00FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
